// File: rtl/uart_rx_frontend.sv
// Serial receive front end: synchronises RX, finds start bits on the 16x tick, 3-sample majority per bit.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd parity) and the parity_error pulse.
module uart_rx_frontend #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD  = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    input  logic       en_16_x_baud,
    input  logic       enable,
    input  logic       buffer_full,
    output logic [7:0] data_out,
    output logic       buffer_write,
    output logic       frame_error,
    output logic       break_detect,
    output logic       overrun,
    output logic       parity_error
);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        PARITY   = 3'd3,
        STOP     = 3'd4,
        BRK_WAIT = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        STOP     = 3'd4,
        BRK_WAIT = 3'd5
    } state_t;
`endif

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    state_t                 state_q, state_d;
    logic [3:0]             tick_q, tick_d;
    logic [2:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [1:0]             samp_q, samp_d;
    logic [7:0]             data_d;
    logic                   write_d, fe_d, brk_d, ovr_d;
    logic                   maj;
    logic                   par_bad;

`ifdef UART_RX_PARITY_EN
    logic                   par_bit_q, par_bit_d;
    logic                   par_d;
    assign par_bad = ((^shift_q) ^ par_bit_q) != PARITY_ODD;
`else
    assign par_bad      = 1'b0;
    assign parity_error = 1'b0;
`endif

    assign rx_s = sync_q[SYNC_STAGES-1];
    // Ticks 7 and 8 are held in samp_q; the live rx_s is the third vote at tick 9.
    assign maj  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], serial_in};
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        samp_d  = samp_q;
        data_d  = data_out;
        write_d = 1'b0;
        fe_d    = 1'b0;
        brk_d   = 1'b0;
        ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d = par_bit_q;
        par_d     = 1'b0;
`endif
        if (!enable) begin
            state_d = IDLE;
            tick_d  = 4'd0;
            bit_d   = 3'd0;
        end else if (en_16_x_baud) begin
            if (state_q != IDLE && state_q != BRK_WAIT) begin
                tick_d = tick_q + 4'd1;
            end
            if (tick_q == 4'd7) samp_d[0] = rx_s;
            if (tick_q == 4'd8) samp_d[1] = rx_s;
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        tick_d  = 4'd0;
                    end
                end
                START: begin
                    if (tick_q == 4'd9 && maj) begin
                        state_d = IDLE;
                        tick_d  = 4'd0;
                    end else if (tick_q == 4'd15) begin
                        state_d = DATA;
                        bit_d   = 3'd0;
                    end
                end
                DATA: begin
                    if (tick_q == 4'd9) begin
                        shift_d = {maj, shift_q[DATA_BITS-1:1]};
                    end else if (tick_q == 4'd15) begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_q == 4'd9) begin
                        par_bit_d = maj;
                    end else if (tick_q == 4'd15) begin
                        state_d = STOP;
                    end
                end
`endif
                STOP: begin
                    // Decide mid stop bit and return to IDLE at once to catch an early next start edge.
                    if (tick_q == 4'd9) begin
                        state_d = IDLE;
                        tick_d  = 4'd0;
                        if (maj) begin
                            data_d = 8'(shift_q);
                            if (par_bad) begin
`ifdef UART_RX_PARITY_EN
                                par_d = 1'b1;
`endif
                            end else if (buffer_full) begin
                                ovr_d = 1'b1;
                            end else begin
                                write_d = 1'b1;
                            end
                        end else if (shift_q != '0) begin
                            data_d = 8'(shift_q);
                            fe_d   = 1'b1;
                        end else begin
                            brk_d   = 1'b1;
                            state_d = BRK_WAIT;
                        end
                    end
                end
                BRK_WAIT: begin
                    if (rx_s) state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    tick_d  = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            tick_q       <= 4'd0;
            bit_q        <= 3'd0;
            shift_q      <= '0;
            samp_q       <= 2'b00;
            data_out     <= 8'h00;
            buffer_write <= 1'b0;
            frame_error  <= 1'b0;
            break_detect <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            samp_q       <= samp_d;
            data_out     <= data_d;
            buffer_write <= write_d;
            frame_error  <= fe_d;
            break_detect <= brk_d;
            overrun      <= ovr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            par_bit_q    <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            par_bit_q    <= par_bit_d;
            parity_error <= par_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend: 8N1 frames at one tick per clk, scoreboarded FIFO writes and pulse counts.
module tb_uart_rx_frontend;

    localparam int DATA_BITS = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       serial_in;
    logic       en_16_x_baud;
    logic       enable;
    logic       buffer_full;
    logic [7:0] data_out;
    logic       buffer_write;
    logic       frame_error;
    logic       break_detect;
    logic       overrun;
    logic       parity_error;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int frame_t0   = 0;
    int last_write_cyc = 0;
    int n_write = 0, n_fe = 0, n_brk = 0, n_ovr = 0, n_par = 0;
    logic [7:0] exp_q[$];

    uart_rx_frontend #(.DATA_BITS(DATA_BITS), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .serial_in    (serial_in),
        .en_16_x_baud (en_16_x_baud),
        .enable       (enable),
        .buffer_full  (buffer_full),
        .data_out     (data_out),
        .buffer_write (buffer_write),
        .frame_error  (frame_error),
        .break_detect (break_detect),
        .overrun      (overrun),
        .parity_error (parity_error)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard / pulse monitor ----------------
    always @(negedge clk) begin
        logic [63:0] exp_v;
        if (buffer_write === 1'b1) begin
            n_write++;
            last_write_cyc = cyc;
            exp_v = (exp_q.size() > 0) ? 64'(exp_q.pop_front()) : 64'hDEAD_BEEF;
            check("write_data", 64'(data_out), exp_v);
        end
        if (frame_error === 1'b1)  n_fe++;
        if (break_detect === 1'b1) n_brk++;
        if (overrun === 1'b1)      n_ovr++;
        if (parity_error === 1'b1) n_par++;
    end

    task automatic expect_pulses(input string tag, input int w, input int fe, input int brk,
                                 input int ovr, input int par);
        check(tag, {8'(n_write), 8'(n_fe), 8'(n_brk), 8'(n_ovr), 8'(n_par)},
                   {8'(w), 8'(fe), 8'(brk), 8'(ovr), 8'(par)});
        n_write = 0; n_fe = 0; n_brk = 0; n_ovr = 0; n_par = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        serial_in = b;
        repeat (16) @(posedge clk);
        #1;
    endtask

    // abort_kind: 0 none, 1 reset pulse, 2 enable drop -- applied mid data bit abort_bit
    task automatic send_frame(input logic [7:0] data, input logic stop_val, input logic par_flip,
                              input int abort_bit, input int abort_kind);
        frame_t0 = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) begin
            if (abort_kind != 0 && i == abort_bit) begin
                serial_in = data[i];
                repeat (8) @(posedge clk);
                #1;
                if (abort_kind == 1) begin
                    reset = 1'b1;
                    @(posedge clk);
                    #1;
                    reset = 1'b0;
                end else begin
                    enable = 1'b0;
                    @(posedge clk);
                    #1;
                    serial_in = 1'b1;
                    repeat (20) @(posedge clk);
                    #1;
                    enable = 1'b1;
                end
                serial_in = 1'b1;
                return;
            end
            drive_bit(data[i]);
        end
`ifdef UART_RX_PARITY_EN
        drive_bit((^data[DATA_BITS-1:0]) ^ par_flip);
`else
        if (par_flip) serial_in = 1'b1;
`endif
        drive_bit(stop_val);
        serial_in = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] d;
        reset = 1'b1;
        serial_in = 1'b1;
        en_16_x_baud = 1'b1;
        enable = 1'b1;
        buffer_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data_out", 64'(data_out), 64'h00);
        check("reset_pulses", 64'({buffer_write, frame_error, break_detect, overrun, parity_error}), 64'h0);
        reset = 1'b0;
        idle(20);
        expect_pulses("post_reset_quiet", 0, 0, 0, 0, 0);

        // 0xA5 good frame and write latency
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0, 0, 0);
        idle(40);
        expect_pulses("a5_pulses", 1, 0, 0, 0, 0);
        check("a5_write_latency", 64'(last_write_cyc - frame_t0), 64'(157 + 16 * (DATA_BITS - 8)
`ifdef UART_RX_PARITY_EN
              + 16
`endif
              ));

        // 5-tick glitch, then 0x3C
        serial_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        idle(40);
        expect_pulses("glitch_quiet", 0, 0, 0, 0, 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, 0, 0);
        idle(40);
        expect_pulses("after_glitch_3c", 1, 0, 0, 0, 0);

        // framing error
        send_frame(8'h3C, 1'b0, 1'b0, 0, 0);
        idle(40);
        expect_pulses("frame_err_pulses", 0, 1, 0, 0, 0);
        check("frame_err_data", 64'(data_out), 64'h3C);

        // break: 40 bit times low
        serial_in = 1'b0;
        repeat (40 * 16) @(posedge clk);
        #1;
        idle(40);
        expect_pulses("break_pulses", 0, 0, 1, 0, 0);
        check("break_data_held", 64'(data_out), 64'h3C);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1'b0, 0, 0);
        idle(40);
        expect_pulses("after_break_55", 1, 0, 0, 0, 0);

        // overrun
        buffer_full = 1'b1;
        send_frame(8'h81, 1'b1, 1'b0, 0, 0);
        idle(40);
        buffer_full = 1'b0;
        expect_pulses("overrun_pulses", 0, 0, 0, 1, 0);
        check("overrun_data", 64'(data_out), 64'h81);

        // reset during data bit 3
        send_frame(8'hF0, 1'b1, 1'b0, 3, 1);
        check("midreset_data_out", 64'(data_out), 64'h00);
        check("midreset_pulses", 64'({buffer_write, frame_error, break_detect, overrun, parity_error}), 64'h0);
        idle(200);
        expect_pulses("midreset_quiet", 0, 0, 0, 0, 0);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, 1'b0, 0, 0);
        idle(40);
        expect_pulses("after_reset_c3", 1, 0, 0, 0, 0);

        // enable drop during data bit 2
        send_frame(8'h0F, 1'b1, 1'b0, 2, 2);
        idle(200);
        expect_pulses("enable_drop_quiet", 0, 0, 0, 0, 0);
        check("enable_drop_data_held", 64'(data_out), 64'hC3);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0, 0, 0);
        idle(40);
        expect_pulses("after_enable_5a", 1, 0, 0, 0, 0);

        // back-to-back random frames with no idle gap
        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom_range(0, 255));
            exp_q.push_back(d);
            send_frame(d, 1'b1, 1'b0, 0, 0);
        end
        idle(40);
        expect_pulses("back_to_back", 4, 0, 0, 0, 0);

`ifdef UART_RX_PARITY_EN
        // 0x07 has odd weight, so even parity wants 1; send 0
        send_frame(8'h07, 1'b1, 1'b1, 0, 0);
        idle(40);
        expect_pulses("parity_err_pulses", 0, 0, 0, 0, 1);
`endif

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
